// File: rtl/syscall_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : syscall_unit_pkg
// Brief   : Shared service codes, register numbers and 7-seg glyph decoder.
// Revision: 1.0
// ============================================================================
package syscall_unit_pkg;

    localparam int unsigned c_REG_V0    = 2;
    localparam int unsigned c_REG_A0    = 4;

    localparam int unsigned c_SYS_PRINT = 1;
    localparam int unsigned c_SYS_EXIT  = 10;
    localparam int unsigned c_SYS_PAUSE = 50;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/syscall_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : syscall_unit_if
// Brief   : Decode-side syscall request, pipeline control and display bundle.
// Revision: 1.0
// ============================================================================
interface syscall_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  syscall;
    logic [DATA_WIDTH-1:0] v0_data;
    logic [DATA_WIDTH-1:0] a0_data;
    logic                  go;
    logic                  stall;
    logic                  halt;
    logic [DATA_WIDTH-1:0] disp_data;
    logic [CNT_WIDTH-1:0]  print_cnt;
    logic [7:0]            an;
    logic [6:0]            seg;

    modport master (
        output syscall, v0_data, a0_data, go,
        input  stall, halt, disp_data, print_cnt, an, seg
    );

    modport slave (
        input  syscall, v0_data, a0_data, go,
        output stall, halt, disp_data, print_cnt, an, seg
    );
endinterface
`default_nettype wire

// File: rtl/syscall_unit_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan
// Brief   : 8-digit multiplexed 7-seg scanner: slot divider, digit index, decoder.
// Revision: 1.0
// ============================================================================
module seg7_scan
    import syscall_unit_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] data,
    output logic      [7:0]  an,
    output logic      [6:0]  seg
);

    localparam int             c_CW      = $clog2(SCAN_DIV);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(SCAN_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_an;
    logic [6:0]      r_seg;

    // an/seg are recomputed every cycle so a new data value appears cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
        end else begin
            if (r_cnt == c_CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            r_an  <= ~(8'h01 << r_idx);
            r_seg <= hex_glyph(data[{r_idx, 2'b00} +: 4]);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule
`default_nettype wire

// File: rtl/syscall_unit.sv
`default_nettype none
// ============================================================================
// Module  : syscall_unit
// Brief   : Services SYSCALL print/pause/exit from v0/a0 and drives the display.
// Revision: 1.0
// ============================================================================
module syscall_unit
    import syscall_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SCAN_DIV   = 50000,
    parameter int CNT_WIDTH  = 16
) (
    input wire logic       clk,
    input wire logic       rst,
    syscall_unit_if.slave  bus
);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_PAUSED = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = c_ST_RUN,
        ST_PAUSED = c_ST_PAUSED,
        ST_HALTED = c_ST_HALTED
    } state_t;

    localparam logic [DATA_WIDTH-1:0] c_V_PRINT = DATA_WIDTH'(c_SYS_PRINT);
    localparam logic [DATA_WIDTH-1:0] c_V_EXIT  = DATA_WIDTH'(c_SYS_EXIT);
    localparam logic [DATA_WIDTH-1:0] c_V_PAUSE = DATA_WIDTH'(c_SYS_PAUSE);

    state_t                r_state;
    logic                  r_stall;
    logic                  r_halt;
    logic [DATA_WIDTH-1:0] r_disp;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [31:0]           w_scan_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_stall <= 1'b0;
            r_halt  <= 1'b0;
            r_disp  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // go is meaningless while running, even alongside a syscall
                    if (bus.syscall) begin
                        if (bus.v0_data == c_V_PRINT) begin
                            r_disp <= bus.a0_data;
                            r_cnt  <= r_cnt + CNT_WIDTH'(1);
                        end else if (bus.v0_data == c_V_EXIT) begin
                            r_state <= ST_HALTED;
                            r_halt  <= 1'b1;
                            r_stall <= 1'b1;
                        end else if (bus.v0_data == c_V_PAUSE) begin
                            r_state <= ST_PAUSED;
                            r_stall <= 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (bus.go) begin
                        r_state <= ST_RUN;
                        r_stall <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    // Scanner always sees 8 nibbles; missing high nibbles read as zero
    generate
        if (DATA_WIDTH >= 32) begin : g_scan_trunc
            assign w_scan_data = r_disp[31:0];
        end else begin : g_scan_pad
            assign w_scan_data = {{(32 - DATA_WIDTH){1'b0}}, r_disp};
        end
    endgenerate

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .data (w_scan_data),
        .an   (bus.an),
        .seg  (bus.seg)
    );

    assign bus.stall     = r_stall;
    assign bus.halt      = r_halt;
    assign bus.disp_data = r_disp;
    assign bus.print_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_syscall_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_syscall_unit
// Brief   : Scoreboard bench for syscall_unit with directed vectors.
// Revision: 1.0
// ============================================================================
module tb_syscall_unit;

    localparam int c_DW = 32;
    localparam int c_CW = 8;
    localparam int c_SD = 4;

    localparam int c_F_STALL = 0;
    localparam int c_F_HALT  = 1;
    localparam int c_F_DISP  = 2;
    localparam int c_F_CNT   = 3;
    localparam int c_F_AN    = 4;
    localparam int c_F_SEG   = 5;

    typedef struct {
        int          due;
        int          field;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    chk_t q[$];

    // Hand-derived glyphs for 32'h0123_4567, digits 0..7 -> nibbles 7..0
    logic [6:0] seg_exp [0:7] = '{7'h78, 7'h02, 7'h12, 7'h19,
                                  7'h30, 7'h24, 7'h79, 7'h40};

    syscall_unit_if #(.DATA_WIDTH(c_DW), .CNT_WIDTH(c_CW)) bus ();

    syscall_unit #(
        .DATA_WIDTH (c_DW),
        .SCAN_DIV   (c_SD),
        .CNT_WIDTH  (c_CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int field);
        case (field)
            c_F_STALL: return {31'b0, bus.stall};
            c_F_HALT:  return {31'b0, bus.halt};
            c_F_DISP:  return bus.disp_data;
            c_F_CNT:   return {24'b0, bus.print_cnt};
            c_F_AN:    return {24'b0, bus.an};
            default:   return {25'b0, bus.seg};
        endcase
    endfunction

    task automatic expect_at(input int field, input logic [31:0] val,
                             input string name, input int delay);
        chk_t c;
        c.due   = cyc + delay;
        c.field = field;
        c.exp   = val;
        c.name  = name;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation that falls due this cycle
    always @(negedge clk) begin
        logic [31:0] act;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].due == cyc) begin
                act = actual(q[k].field);
                checks++;
                if (act !== q[k].exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             q[k].name, act, q[k].exp, cyc);
                end
                q.delete(k);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.syscall = 1'b0;
        bus.go      = 1'b0;
        bus.v0_data = '0;
        bus.a0_data = '0;

        // Reset values
        tick(); tick();
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL direct_rst_stall: got %b expected 0", bus.stall);
        end
        checks++;
        if (bus.halt !== 1'b0) begin
            errors++;
            $display("FAIL direct_rst_halt: got %b expected 0", bus.halt);
        end
        checks++;
        if (bus.an !== 8'hFF) begin
            errors++;
            $display("FAIL direct_rst_an: got %h expected FF", bus.an);
        end
        expect_at(c_F_STALL, 0,     "rst_stall", 0);
        expect_at(c_F_HALT,  0,     "rst_halt",  0);
        expect_at(c_F_DISP,  0,     "rst_disp",  0);
        expect_at(c_F_CNT,   0,     "rst_cnt",   0);
        expect_at(c_F_AN,    8'hFF, "rst_an",    0);
        expect_at(c_F_SEG,   7'h7F, "rst_seg",   0);
        rst = 1'b0;
        expect_at(c_F_AN,  8'hFE, "first_digit_an",  1);
        expect_at(c_F_SEG, 7'h40, "first_digit_seg", 1);
        tick();

        // Print
        bus.v0_data = 1; bus.a0_data = 32'hDEADBEEF; bus.syscall = 1'b1;
        expect_at(c_F_DISP, 32'hDEADBEEF, "print_disp", 1);
        expect_at(c_F_CNT,  1,            "print_cnt",  1);
        tick();
        bus.syscall = 1'b0;
        tick();

        // Counter wrap: 255 back-to-back prints take 1 -> 0 (8-bit)
        bus.a0_data = 32'h0123_4567; bus.syscall = 1'b1;
        expect_at(c_F_CNT,  8'hFF,        "cnt_ff",    254);
        expect_at(c_F_CNT,  0,            "cnt_wrap",  255);
        expect_at(c_F_DISP, 32'h01234567, "wrap_disp", 255);
        repeat (255) tick();
        bus.syscall = 1'b0;
        tick();

        // Unknown services and go in RUN
        bus.v0_data = 32'h0001_0001; bus.syscall = 1'b1;
        expect_at(c_F_CNT,   0,            "upper_cnt",   1);
        expect_at(c_F_DISP,  32'h01234567, "upper_disp",  1);
        expect_at(c_F_STALL, 0,            "upper_stall", 1);
        expect_at(c_F_HALT,  0,            "upper_halt",  1);
        tick();
        bus.v0_data = 7;
        expect_at(c_F_CNT,   0, "v7_cnt",   1);
        expect_at(c_F_STALL, 0, "v7_stall", 1);
        tick();
        bus.syscall = 1'b0; bus.go = 1'b1;
        expect_at(c_F_STALL, 0, "go_run_stall", 1);
        tick();
        bus.go = 1'b0;

        // Pause with simultaneous go (go ignored), then syscalls while paused
        bus.v0_data = 50; bus.syscall = 1'b1; bus.go = 1'b1;
        expect_at(c_F_STALL, 1, "pause_stall",      1);
        expect_at(c_F_STALL, 1, "pause_stall_hold", 2);
        tick();
        bus.syscall = 1'b0; bus.go = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.syscall = i[0];
            bus.v0_data = (i < 10) ? 1 : 10;
            bus.a0_data = 32'hFFFF_FFFF;
            tick();
        end
        bus.syscall = 1'b0;
        expect_at(c_F_STALL, 1,            "paused_stall", 0);
        expect_at(c_F_HALT,  0,            "paused_halt",  0);
        expect_at(c_F_DISP,  32'h01234567, "paused_disp",  0);
        expect_at(c_F_CNT,   0,            "paused_cnt",   0);
        bus.go = 1'b1;
        expect_at(c_F_STALL, 0, "resume_stall", 1);
        tick();
        bus.go = 1'b0;

        // Exit, then everything ignored until reset
        bus.v0_data = 10; bus.syscall = 1'b1;
        expect_at(c_F_HALT,  1, "exit_halt",  1);
        expect_at(c_F_STALL, 1, "exit_stall", 1);
        tick();
        bus.go = 1'b1; bus.v0_data = 1; bus.a0_data = 32'hAAAA_5555;
        expect_at(c_F_HALT,  1,            "halted_halt",  1);
        expect_at(c_F_STALL, 1,            "halted_stall", 1);
        expect_at(c_F_DISP,  32'h01234567, "halted_disp",  1);
        expect_at(c_F_CNT,   0,            "halted_cnt",   1);
        tick();
        bus.go = 1'b0; bus.syscall = 1'b0;
        tick();
        rst = 1'b1;
        expect_at(c_F_HALT,  0, "rst_exit_halt",  1);
        expect_at(c_F_STALL, 0, "rst_exit_stall", 1);
        expect_at(c_F_DISP,  0, "rst_exit_disp",  1);
        tick();

        // Scanner: release reset and print 0123_4567 on the same edge
        rst = 1'b0;
        bus.v0_data = 1; bus.a0_data = 32'h0123_4567; bus.syscall = 1'b1;
        expect_at(c_F_AN,  8'hFE, "scan_an_first",  1);
        expect_at(c_F_SEG, 7'h40, "scan_seg_first", 1);
        for (int d = 0; d < 8; d++) begin
            expect_at(c_F_AN,  {24'b0, ~(8'h01 << d)}, $sformatf("scan_an%0d", d),      2 + 4 * d);
            expect_at(c_F_SEG, {25'b0, seg_exp[d]},    $sformatf("scan_seg%0d", d),     2 + 4 * d);
            expect_at(c_F_AN,  {24'b0, ~(8'h01 << d)}, $sformatf("scan_an%0d_end", d),  4 + 4 * d);
        end
        expect_at(c_F_AN, 8'hFE, "scan_wrap_an", 33);
        tick();
        bus.syscall = 1'b0;
        repeat (34) tick();

        // Reset while paused
        bus.v0_data = 50; bus.syscall = 1'b1;
        expect_at(c_F_STALL, 1, "pause2_stall", 1);
        tick();
        bus.syscall = 1'b0;
        tick();
        rst = 1'b1;
        expect_at(c_F_STALL, 0,     "rst_pause_stall", 1);
        expect_at(c_F_AN,    8'hFF, "rst_pause_an",    1);
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL direct_post_rst_stall: got %b expected 0", bus.stall);
        end
        checks++;
        if (bus.halt !== 1'b0) begin
            errors++;
            $display("FAIL direct_post_rst_halt: got %b expected 0", bus.halt);
        end
        checks++;
        if (bus.an !== 8'hFE) begin
            errors++;
            $display("FAIL direct_post_rst_an: got %h expected FE", bus.an);
        end

        // Drain with a bounded wait
        for (int t = 0; t < 100 && q.size() > 0; t++) tick();
        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no sample expected %h (timeout)", q[0].name, q[0].exp);
            void'(q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
